// File: rtl/seg7_counter_display.sv
// seg7_counter_display
// Rising-edge detects three debounced buttons, keeps a 4-digit BCD up/down
// counter and time-multiplexes it onto a 4-digit common-anode display.
// Handshake: none; the button inputs are plain synchronous levels and every
// output is a registered level that updates on the rising clk edge.

module seg7_counter_display #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_clr,
    output logic [15:0] count,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int             PW     = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]  P_LAST = PW'(REFRESH_DIV - 1);

    logic          r_prev_up;
    logic          r_prev_down;
    logic          r_prev_clr;
    logic [15:0]   r_count;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_sel;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic          w_rise_up;
    logic          w_rise_down;
    logic          w_rise_clr;
    logic [15:0]   w_count_inc;
    logic [15:0]   w_count_dec;
    logic [15:0]   w_count_next;
    logic          w_presc_last;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [6:0]    w_seg_next;
    logic [3:0]    w_an_next;

    // Segment pattern {g,f,e,d,c,b,a}, active-low; non-BCD codes are dark.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] v;
        case (d)
            4'd0:    v = 7'b1000000;
            4'd1:    v = 7'b1111001;
            4'd2:    v = 7'b0100100;
            4'd3:    v = 7'b0110000;
            4'd4:    v = 7'b0011001;
            4'd5:    v = 7'b0010010;
            4'd6:    v = 7'b0000010;
            4'd7:    v = 7'b1111000;
            4'd8:    v = 7'b0000000;
            4'd9:    v = 7'b0010000;
            default: v = 7'b1111111;
        endcase
        return v;
    endfunction

    assign w_rise_up   = btn_up   & ~r_prev_up;
    assign w_rise_down = btn_down & ~r_prev_down;
    assign w_rise_clr  = btn_clr  & ~r_prev_clr;

    // Per-digit BCD increment: a 9 rolls to 0 and carries upward.
    always_comb begin
        logic w_carry;
        w_count_inc = r_count;
        w_carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    // Per-digit BCD decrement: a 0 rolls to 9 and borrows upward.
    always_comb begin
        logic w_borrow;
        w_count_dec = r_count;
        w_borrow    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_count_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    w_borrow              = 1'b0;
                end
            end
        end
    end

    // Event priority: clear wins, up+down together cancel, then up, then down.
    always_comb begin
        w_count_next = r_count;
        if (w_rise_clr) begin
            w_count_next = 16'h0000;
        end else if (w_rise_up && w_rise_down) begin
            w_count_next = r_count;
        end else if (w_rise_up) begin
            w_count_next = w_count_inc;
        end else if (w_rise_down) begin
            w_count_next = w_count_dec;
        end
    end

    // Display word for the current slot, blanking leading zero digits 3..1.
    always_comb begin
        w_digit = r_count[{r_sel, 2'b00} +: 4];
        case (r_sel)
            2'd1:    w_blank = BLANK_LEADING && (r_count[15:4]  == 12'h000);
            2'd2:    w_blank = BLANK_LEADING && (r_count[15:8]  == 8'h00);
            2'd3:    w_blank = BLANK_LEADING && (r_count[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
        if (w_blank) begin
            w_an_next  = 4'b1111;
            w_seg_next = 7'b1111111;
        end else begin
            w_an_next  = ~(4'b0001 << r_sel);
            w_seg_next = f_decode(w_digit);
        end
    end

    assign w_presc_last = (r_presc == P_LAST);

    // Edge history, counter, scan prescaler/select and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev_up   <= 1'b1;
            r_prev_down <= 1'b1;
            r_prev_clr  <= 1'b1;
            r_count     <= 16'h0000;
            r_presc     <= '0;
            r_sel       <= 2'd0;
            r_seg       <= 7'b1111111;
            r_an        <= 4'b1111;
        end else begin
            r_prev_up   <= btn_up;
            r_prev_down <= btn_down;
            r_prev_clr  <= btn_clr;
            r_count     <= w_count_next;
            if (w_presc_last) begin
                r_presc <= '0;
                r_sel   <= r_sel + 2'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign count = r_count;
    assign seg   = r_seg;
    assign an    = r_an;
    assign dp    = 1'b1;

endmodule

// File: tb/tb_seg7_counter_display.sv
// Bench for seg7_counter_display: two instances (leading-zero blanking on and
// off) share the inputs and are compared every cycle against an integer model,
// plus a vector table and hand-written corner-case sequences.

module tb_seg7_counter_display;

  localparam int RD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic btn_clr = 1'b0;

  logic [15:0] count_b, count_n;
  logic [6:0]  seg_b, seg_n;
  logic        dp_b, dp_n;
  logic [3:0]  an_b, an_n;

  int total = 0;
  int bad = 0;

  // clock/reset block
  always #5 clk = ~clk;

  seg7_counter_display #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut_b (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .count(count_b), .seg(seg_b), .dp(dp_b), .an(an_b)
  );

  seg7_counter_display #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) dut_n (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .count(count_n), .seg(seg_n), .dp(dp_n), .an(an_n)
  );

  // reference model: count as an integer 0..9999, scan as a phase 0..4*RD-1
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int pow10 [4] = '{1, 10, 100, 1000};

  int         m_cnt = 0;
  bit [2:0]   m_prev = 3'b111;
  int         m_phase = 0;
  bit         m_valid = 1'b0;
  logic [3:0] m_an_b = 4'hf, m_an_n = 4'hf;
  logic [6:0] m_seg_b = 7'h7f, m_seg_n = 7'h7f;
  int         m_k, m_dig;
  bit         m_ru, m_rd, m_rc;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_cnt = 0; m_prev = 3'b111; m_phase = 0; m_valid = 1'b1;
      m_an_b = 4'hf; m_an_n = 4'hf; m_seg_b = 7'h7f; m_seg_n = 7'h7f;
    end else begin
      m_k = m_phase / RD;
      m_dig = (m_cnt / pow10[m_k]) % 10;
      m_an_n = 4'hf;
      m_an_n[m_k] = 1'b0;
      m_seg_n = seg_tab[m_dig];
      if (m_k > 0 && (m_cnt / pow10[m_k]) == 0) begin
        m_an_b = 4'hf; m_seg_b = 7'h7f;
      end else begin
        m_an_b = m_an_n; m_seg_b = m_seg_n;
      end
      m_ru = btn_up && !m_prev[2];
      m_rd = btn_down && !m_prev[1];
      m_rc = btn_clr && !m_prev[0];
      if (m_rc) m_cnt = 0;
      else if (m_ru && m_rd) m_cnt = m_cnt;
      else if (m_ru) m_cnt = (m_cnt + 1) % 10000;
      else if (m_rd) m_cnt = (m_cnt + 9999) % 10000;
      m_prev = {btn_up, btn_down, btn_clr};
      m_phase = (m_phase + 1) % (4 * RD);
    end
  end

  // scoreboard compare
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_count_b", count_b, to_bcd(m_cnt));
      chk("model_count_n", count_n, to_bcd(m_cnt));
      chk("model_an_b", {12'h0, an_b}, {12'h0, m_an_b});
      chk("model_seg_b", {9'h0, seg_b}, {9'h0, m_seg_b});
      chk("model_an_n", {12'h0, an_n}, {12'h0, m_an_n});
      chk("model_seg_n", {9'h0, seg_n}, {9'h0, m_seg_n});
      chk("dp", {14'h0, dp_b, dp_n}, 16'h0003);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic u, input logic d, input logic c);
    btn_up = u; btn_down = d; btn_clr = c;
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    tick();
  endtask

  task automatic load(input int n);
    press(1'b0, 1'b0, 1'b1);
    repeat (n) press(1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    int          load_val;
    logic        up;
    logic        down;
    logic        clr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  initial begin
    vecs[0] = '{0,   1'b0, 1'b1, 1'b0, 16'h9999};
    vecs[1] = '{-1,  1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{42,  1'b1, 1'b1, 1'b0, 16'h0042};
    vecs[3] = '{42,  1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[4] = '{10,  1'b0, 1'b1, 1'b0, 16'h0009};
    vecs[5] = '{100, 1'b0, 1'b1, 1'b0, 16'h0099};
    vecs[6] = '{-1,  1'b1, 1'b0, 1'b0, 16'h0100};
    vecs[7] = '{-1,  1'b0, 1'b0, 1'b1, 16'h0000};

    // reset held for 3 cycles
    reset = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_count", count_b, 16'h0000);
      chk("rst_an", {12'h0, an_b}, 16'h000f);
      chk("rst_seg", {9'h0, seg_b}, 16'h007f);
    end
    reset = 1'b1;
    tick();
    chk("rel_an", {12'h0, an_b}, 16'h000e);
    chk("rel_seg", {9'h0, seg_b}, 16'h0040);
    repeat (RD) tick();
    chk("blank_slot1_an", {12'h0, an_b}, 16'h000f);
    chk("noblank_slot1_an", {12'h0, an_n}, 16'h000d);

    // five long presses -> five increments
    repeat (5) begin
      btn_up = 1'b1;
      repeat (50) tick();
      btn_up = 1'b0;
      repeat (10) tick();
    end
    chk("five_presses", count_b, 16'h0005);

    // vector table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].load_val >= 0) load(vecs[i].load_val);
      press(vecs[i].up, vecs[i].down, vecs[i].clr);
      chk($sformatf("vec%0d", i), count_b, vecs[i].exp);
    end

    // carry through three digits, then look at the thousands slot
    load(999);
    press(1'b1, 1'b0, 1'b0);
    chk("carry_1000", count_b, 16'h1000);
    begin
      int n = 0;
      while (an_b !== 4'b0111 && n < 4 * RD + 2) begin tick(); n++; end
      chk("thousands_slot_an", {12'h0, an_b}, 16'h0007);
      chk("thousands_slot_seg", {9'h0, seg_b}, 16'h0079);
    end

    // button held through reset release produces no event
    btn_up = 1'b1;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("held_through_reset", count_b, 16'h0000);
    btn_up = 1'b0;
    tick();
    btn_up = 1'b1;
    tick();
    chk("press_after_hold", count_b, 16'h0001);
    btn_up = 1'b0;
    tick();

    // full scan of 1234 without blanking
    load(1234);
    chk("load_1234", count_n, 16'h1234);
    begin
      int n = 0;
      logic [3:0] last;
      last = an_n;
      tick();
      while (!(an_n === 4'b1110 && last !== 4'b1110) && n < 4 * RD + 4) begin
        last = an_n;
        tick();
        n++;
      end
      chk("scan_align", {12'h0, an_n}, 16'h000e);
      for (int i = 0; i < 8 * RD; i++) begin
        chk($sformatf("scan_an%0d", i), {12'h0, an_n}, {12'h0, exp_an[(i / RD) % 4]});
        chk($sformatf("scan_seg%0d", i), {9'h0, seg_n}, {9'h0, exp_seg[(i / RD) % 4]});
        tick();
      end
    end

    // reset in the middle of a slot restarts the scan at digit 0
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("midslot_rst_an_n", {12'h0, an_n}, 16'h000f);
    chk("midslot_rst_an_b", {12'h0, an_b}, 16'h000f);
    chk("midslot_rst_count", count_n, 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < RD; i++) begin
      tick();
      chk("restart_an", {12'h0, an_n}, 16'h000e);
      chk("restart_seg", {9'h0, seg_n}, 16'h0040);
    end
    tick();
    chk("restart_slot1", {12'h0, an_n}, 16'h000d);

    // randomized button activity, checked against the model every cycle
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 6) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 40) == 0) btn_clr = ~btn_clr;
      reset = ($urandom_range(0, 300) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    reset = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    repeat (4) tick();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
